// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from PCF; learning and statistics update from Execute.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        predicted_takenF,
    output logic [31:0] predicted_targetF,
    input  logic        BranchResolvedE,
    input  logic [31:0] PCE,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        predicted_takenE,
    input  logic [31:0] predicted_targetE,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [31:0]     target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    logic [IDXW-1:0] idx_f_s, idx_e_s;
    logic [TAGW-1:0] tag_f_s, tag_e_s;
    logic            hit_f_s, hit_e_s, mispredict_s;
    logic            upd_valid_d;
    logic [TAGW-1:0] upd_tag_d;
    logic [31:0]     upd_target_d;
    logic [1:0]      upd_ctr_d;
    logic            unused_pce_low_s;

    assign idx_f_s          = PCF[IDXW+1:2];
    assign tag_f_s          = PCF[31:IDXW+2];
    assign idx_e_s          = PCE[IDXW+1:2];
    assign tag_e_s          = PCE[31:IDXW+2];
    assign unused_pce_low_s = ^PCE[1:0];

    // Fetch-side lookup: taken only on a tag hit with the counter in a taken state.
    always_comb begin
        hit_f_s           = valid_q[idx_f_s] && (tag_q[idx_f_s] == tag_f_s);
        predicted_takenF  = hit_f_s && ctr_q[idx_f_s][1];
        predicted_targetF = PCF + 32'd4;
        if (predicted_takenF) begin
            predicted_targetF = target_q[idx_f_s];
        end else begin
            predicted_targetF = PCF + 32'd4;
        end
    end

    // Next contents of the entry addressed by the resolving branch.
    always_comb begin
        hit_e_s      = valid_q[idx_e_s] && (tag_q[idx_e_s] == tag_e_s);
        upd_valid_d  = valid_q[idx_e_s];
        upd_tag_d    = tag_q[idx_e_s];
        upd_target_d = target_q[idx_e_s];
        upd_ctr_d    = ctr_q[idx_e_s];
        if (hit_e_s) begin
            if (PCSrcE) begin
                upd_ctr_d    = sat_inc(ctr_q[idx_e_s]);
                upd_target_d = PCTargetE;
            end else begin
                upd_ctr_d    = sat_dec(ctr_q[idx_e_s]);
            end
        end else if (PCSrcE) begin
            // Not-taken misses never allocate, so cold branches stay out of the table.
            upd_valid_d  = 1'b1;
            upd_tag_d    = tag_e_s;
            upd_target_d = PCTargetE;
            upd_ctr_d    = 2'b10;
        end else begin
            upd_valid_d  = valid_q[idx_e_s];
        end
    end

    // Table storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (BranchResolvedE) begin
            valid_q[idx_e_s]  <= upd_valid_d;
            tag_q[idx_e_s]    <= upd_tag_d;
            target_q[idx_e_s] <= upd_target_d;
            ctr_q[idx_e_s]    <= upd_ctr_d;
        end
    end

    // Mispredict uses the same condition as the Execute flush logic; counters wrap.
    always_comb begin
        mispredict_s = (predicted_takenE != PCSrcE) ||
                       (predicted_takenE && (predicted_targetE != PCTargetE));
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (BranchResolvedE) begin
            branch_count_d = branch_count_q + 32'd1;
            if (mispredict_s) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end else begin
                mispredict_count_d = mispredict_count_q;
            end
        end else begin
            branch_count_d = branch_count_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage direction predictor and branch target buffer. It supplies `predicted_takenF` and `predicted_targetF` for the PC being fetched, and learns from the branch outcomes resolved in Execute. It is the producer of the prediction that the Execute-stage flush logic checks against the actual outcome. The block also keeps branch and mispredict statistics counters for performance measurement.

## Interface
Parameters:
- `ENTRIES`, default 16: table depth; must be a power of 2 and at least 2. `IDXW = log2(ENTRIES)`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PCF`  in  32  PC being fetched.
- `predicted_takenF`  out  1  predict taken for `PCF`.
- `predicted_targetF`  out  32  predicted next PC for `PCF`.
- `BranchResolvedE`  in  1  a branch or jump in Execute resolved this cycle.
- `PCE`  in  32  PC of the resolving instruction.
- `PCSrcE`  in  1  actual taken.
- `PCTargetE`  in  32  actual target.
- `predicted_takenE`  in  1  prediction made for this instruction in Fetch, piped through to Execute.
- `predicted_targetE`  in  32  target prediction made in Fetch, piped through to Execute.
- `branch_count`  out  32  number of resolved branches.
- `mispredict_count`  out  32  number of mispredicted branches.

## Operation
- Each entry holds `valid` (1), `tag` (`30-IDXW` bits), `target` (32) and a 2-bit saturating counter `ctr`.
- Index is `PC[IDXW+1:2]`; tag is `PC[31:IDXW+2]`. `PC[1:0]` is ignored.
- Lookup (combinational from `PCF`):
  - Hit means `valid` is set and `tag` matches.
  - `predicted_takenF = hit & ctr[1]`.
  - `predicted_targetF` is the entry's `target` when `predicted_takenF` is 1, otherwise `PCF + 4` (mod 2^32).
- Update when `BranchResolvedE` = 1, using `PCE` for index and tag:
  - Hit, `PCSrcE` = 1: `ctr` saturating-increments (max 11); `target <= PCTargetE`.
  - Hit, `PCSrcE` = 0: `ctr` saturating-decrements (min 00); `target` is unchanged.
  - Miss, `PCSrcE` = 1: allocate by overwriting the indexed entry with `valid=1`, new tag, `target=PCTargetE`, `ctr=10` (weakly taken).
  - Miss, `PCSrcE` = 0: no change.
- Mispredict is defined as `(predicted_takenE != PCSrcE) | (predicted_takenE & (predicted_targetE != PCTargetE))`.
  - This is the same condition the flush logic uses.
- Statistics, only when `BranchResolvedE` = 1:
  - `branch_count` increments.
  - `mispredict_count` increments when a mispredict is detected.
  - Both counters wrap from 0xFFFFFFFF to 0.
- When `BranchResolvedE` = 0, no state changes.

## Timing
- Lookup has zero latency: the outputs are valid in the same cycle as `PCF`.
- An update is written at the rising edge following a cycle in which `BranchResolvedE` = 1. It is visible to lookups from the next cycle onward.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents. There is no write-to-read bypass.
- Reset (asynchronous, on `rst_n` low, at any time including mid-update):
  - All `valid` are cleared to 0 and all `ctr` set to 01.
  - `tag` and `target` are cleared to 0.
  - `branch_count` and `mispredict_count` are cleared to 0.
  - As a result, `predicted_takenF` = 0 and `predicted_targetF` = `PCF + 4` while in reset.
- An update pending in the cycle `rst_n` asserts is lost.
- First update after release: `rst_n` deasserts asynchronously. The first possible update lands on the first rising edge at which `rst_n` is high and `BranchResolvedE` = 1.
- Aliasing: two PCs with the same index but different tags evict each other (direct-mapped). A tag mismatch is always treated as a miss.

## Test plan
- **Reset:** after reset with `PCF`=0x40, expect `predicted_takenF`=0, `predicted_targetF`=0x44, both counters 0. Asserting `rst_n` low mid-run clears an allocated entry and the counters immediately.
- **Allocate:** resolve `PCE`=0x40, taken, target 0x100. Next cycle `PCF`=0x40 gives taken/0x100. In the same cycle as that resolve, a lookup of 0x40 still gives not-taken/0x44.
- **Hysteresis:** from `ctr`=10 at 0x40, one not-taken resolve gives not-taken/0x44. A following taken resolve gives taken again. Three more taken resolves saturate `ctr` at 11. Then two not-taken resolves are needed before the prediction flips to not-taken.
- **Alias** (`ENTRIES`=16): allocate 0x40 to target 0x100, then allocate 0x80 to target 0x200. Lookup of 0x40 misses (returns 0x44); lookup of 0x80 predicts 0x200. A not-taken resolve of 0xC0 (same index, miss) leaves the 0x80 entry intact.
- **Statistics:** apply 5 resolves:
  - (pred NT, actual T)
  - (pred T 0x100, actual T 0x100)
  - (pred T 0x100, actual T 0x104)
  - (pred NT, actual NT)
  - (pred T, actual NT)
  - Expect `branch_count`=5 and `mispredict_count`=3.
- **Wrap:** with the counters preset to 0xFFFFFFFF, one mispredicted resolve leaves both counters at 0.
